// File: rtl/binary_matmul_accum_core_if.sv
// Stream bundle for the binary matmul core: two joined operand streams in,
// one signed result tile out, plus mode select and busy status.
interface binary_matmul_accum_core_if #(
    parameter int IN1_PARALLELISM = 4,
    parameter int IN_SIZE         = 3,
    parameter int IN2_PARALLELISM = 5,
    parameter int OUT_WIDTH       = 8
);
    logic [IN1_PARALLELISM*IN_SIZE-1:0]           data_in1;
    logic                                         data_in1_valid;
    logic                                         data_in1_ready;
    logic [IN_SIZE*IN2_PARALLELISM-1:0]           data_in2;
    logic                                         data_in2_valid;
    logic                                         data_in2_ready;
    logic                                         mode;
    logic [IN1_PARALLELISM*IN2_PARALLELISM*OUT_WIDTH-1:0] data_out;
    logic                                         data_out_valid;
    logic                                         data_out_ready;
    logic                                         busy;

    modport master (
        output data_in1, data_in1_valid, data_in2, data_in2_valid, mode, data_out_ready,
        input  data_in1_ready, data_in2_ready, data_out, data_out_valid, busy
    );

    modport slave (
        input  data_in1, data_in1_valid, data_in2, data_in2_valid, mode, data_out_ready,
        output data_in1_ready, data_in2_ready, data_out, data_out_valid, busy
    );
endinterface

// File: rtl/binary_matmul_accum_core.sv
// Tiled binary matrix multiply: per beat popcount of XNOR/AND products, accumulated over
// IN_DEPTH beats into a signed, optionally saturated result tile with a one-deep output buffer.
module binary_matmul_accum_core #(
    parameter int IN1_PARALLELISM = 4,
    parameter int IN_SIZE         = 3,
    parameter int IN2_PARALLELISM = 5,
    parameter int IN_DEPTH        = 3,
    parameter int OUT_WIDTH       = 8,
    parameter int SATURATE        = 1
) (
    input logic clk,
    input logic rst,
    binary_matmul_accum_core_if.slave bus
);
    localparam int N      = IN1_PARALLELISM;
    localparam int K      = IN_SIZE;
    localparam int M      = IN2_PARALLELISM;
    localparam int E      = N * M;
    localparam int L      = IN_SIZE * IN_DEPTH;
    localparam int ACC_W  = $clog2(L + 1) + 1;
    localparam int CNT_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int EXT_W  = (((ACC_W + 1) > OUT_WIDTH) ? (ACC_W + 1) : OUT_WIDTH) + 1;

    localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(IN_DEPTH - 1);
    localparam logic [CNT_W-1:0]        CNT_ZERO  = CNT_W'(0);
    localparam logic signed [EXT_W-1:0] L_EXT     = EXT_W'(L);
    localparam logic signed [EXT_W-1:0] SAT_MAX   = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN   = ~SAT_MAX;

    function automatic logic [ACC_W-1:0] beat_count(
        input logic [K-1:0] a_row,
        input logic [K-1:0] b_col,
        input logic         and_mode
    );
        logic [ACC_W-1:0] c;
        logic             hit;
        c = '0;
        for (int k = 0; k < K; k++) begin
            if (and_mode) begin
                hit = a_row[k] & b_col[k];
            end else begin
                hit = ~(a_row[k] ^ b_col[k]);
            end
            c = c + {{(ACC_W-1){1'b0}}, hit};
        end
        return c;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] cast_out(input logic signed [EXT_W-1:0] v);
        logic [OUT_WIDTH-1:0] r;
        if (SATURATE != 0) begin
            if (v > SAT_MAX) begin
                r = SAT_MAX[OUT_WIDTH-1:0];
            end else if (v < SAT_MIN) begin
                r = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                r = v[OUT_WIDTH-1:0];
            end
        end else begin
            r = v[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    logic [CNT_W-1:0]       r_beat_cnt;
    logic [ACC_W-1:0]       r_acc [E];
    logic                   r_mode_q;
    logic [E*OUT_WIDTH-1:0] r_data_out;
    logic                   r_out_valid;
    logic                   r_busy;

    logic                   w_first;
    logic                   w_last;
    logic                   w_in_ready;
    logic                   w_fire;
    logic                   w_mode;
    logic [K-1:0]           w_a_row [N];
    logic [K-1:0]           w_b_col [M];
    logic [ACC_W-1:0]       w_sum   [E];
    logic [E*OUT_WIDTH-1:0] w_result;

    // The last beat may only stall while a finished tile is still waiting downstream.
    assign w_first    = (r_beat_cnt == CNT_ZERO);
    assign w_last     = (r_beat_cnt == LAST_BEAT);
    assign w_in_ready = ~w_last | ~r_out_valid | bus.data_out_ready;
    assign w_fire     = bus.data_in1_valid & bus.data_in2_valid & w_in_ready;
    assign w_mode     = w_first ? bus.mode : r_mode_q;

    assign bus.data_in1_ready = w_in_ready;
    assign bus.data_in2_ready = w_in_ready;
    assign bus.data_out       = r_data_out;
    assign bus.data_out_valid = r_out_valid;
    assign bus.busy           = r_busy;

    // Unpack A rows and transpose B into columns for the per-element dot products.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_a_row[i] = bus.data_in1[i*K +: K];
        end
        for (int j = 0; j < M; j++) begin
            w_b_col[j] = '0;
            for (int k = 0; k < K; k++) begin
                w_b_col[j][k] = bus.data_in2[k*M + j];
            end
        end
    end

    // Running sums including this beat, and the cast result tile if this beat closes it.
    always_comb begin
        logic [ACC_W-1:0]        v_p;
        logic signed [EXT_W-1:0] v_ext;
        logic signed [EXT_W-1:0] v_res;
        v_p      = '0;
        v_ext    = '0;
        v_res    = '0;
        w_result = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                v_p = beat_count(w_a_row[i], w_b_col[j], w_mode);
                if (w_first) begin
                    w_sum[i*M + j] = v_p;
                end else begin
                    w_sum[i*M + j] = r_acc[i*M + j] + v_p;
                end
                v_ext = $signed({{(EXT_W-ACC_W){1'b0}}, w_sum[i*M + j]});
                if (w_mode) begin
                    v_res = v_ext;
                end else begin
                    v_res = (v_ext <<< 1) - L_EXT;
                end
                w_result[(i*M + j)*OUT_WIDTH +: OUT_WIDTH] = cast_out(v_res);
            end
        end
    end

    // Beat counter, tile mode latch and accumulators advance on every accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= CNT_ZERO;
            r_mode_q   <= 1'b0;
            r_busy     <= 1'b0;
            for (int e = 0; e < E; e++) begin
                r_acc[e] <= '0;
            end
        end else if (w_fire) begin
            for (int e = 0; e < E; e++) begin
                r_acc[e] <= w_sum[e];
            end
            if (w_first) begin
                r_mode_q <= bus.mode;
            end
            if (w_last) begin
                r_beat_cnt <= CNT_ZERO;
                r_busy     <= 1'b0;
            end else begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1'b1);
                r_busy     <= 1'b1;
            end
        end
    end

    // Output buffer: load on a closing beat (even while draining), otherwise drop after handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_fire & w_last) begin
            r_data_out  <= w_result;
            r_out_valid <= 1'b1;
        end else if (r_out_valid & bus.data_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_binary_matmul_accum_core.sv
// Scoreboard bench: three cores (8-bit saturating, 4-bit saturating, 4-bit truncating) share
// one stimulus stream; expected tiles are queued per core and checked by a monitor.
module tb_binary_matmul_accum_core;
    typedef struct { int c[20]; } tile_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] d1 = 12'd0;
    logic [14:0] d2 = 15'd0;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;
    logic        mode = 1'b0;
    logic        oready = 1'b1;

    int    total = 0;
    int    bad = 0;
    tile_t q8[$];
    tile_t q4s[$];
    tile_t q4t[$];
    logic [11:0] rec_a [3];
    logic [14:0] rec_b [3];
    logic        rec_m;
    bit          rnd_done = 1'b0;

    always #5 clk = ~clk;

    binary_matmul_accum_core_if #(.IN1_PARALLELISM(4), .IN_SIZE(3), .IN2_PARALLELISM(5), .OUT_WIDTH(8)) b8 ();
    binary_matmul_accum_core_if #(.IN1_PARALLELISM(4), .IN_SIZE(3), .IN2_PARALLELISM(5), .OUT_WIDTH(4)) b4s ();
    binary_matmul_accum_core_if #(.IN1_PARALLELISM(4), .IN_SIZE(3), .IN2_PARALLELISM(5), .OUT_WIDTH(4)) b4t ();

    assign b8.data_in1  = d1; assign b8.data_in2  = d2; assign b8.data_in1_valid  = v1;
    assign b8.data_in2_valid  = v2; assign b8.mode  = mode; assign b8.data_out_ready  = oready;
    assign b4s.data_in1 = d1; assign b4s.data_in2 = d2; assign b4s.data_in1_valid = v1;
    assign b4s.data_in2_valid = v2; assign b4s.mode = mode; assign b4s.data_out_ready = oready;
    assign b4t.data_in1 = d1; assign b4t.data_in2 = d2; assign b4t.data_in1_valid = v1;
    assign b4t.data_in2_valid = v2; assign b4t.mode = mode; assign b4t.data_out_ready = oready;

    binary_matmul_accum_core #(.IN1_PARALLELISM(4), .IN_SIZE(3), .IN2_PARALLELISM(5), .IN_DEPTH(3),
        .OUT_WIDTH(8), .SATURATE(1)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));
    binary_matmul_accum_core #(.IN1_PARALLELISM(4), .IN_SIZE(3), .IN2_PARALLELISM(5), .IN_DEPTH(3),
        .OUT_WIDTH(4), .SATURATE(1)) u_dut4s (.clk(clk), .rst(rst), .bus(b4s));
    binary_matmul_accum_core #(.IN1_PARALLELISM(4), .IN_SIZE(3), .IN2_PARALLELISM(5), .IN_DEPTH(3),
        .OUT_WIDTH(4), .SATURATE(0)) u_dut4t (.clk(clk), .rst(rst), .bus(b4t));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cast_v(input int v, input int ow, input bit sat);
        int hi = (1 << (ow - 1)) - 1;
        int lo = -(1 << (ow - 1));
        int t;
        if (sat) begin
            if (v > hi) return hi;
            if (v < lo) return lo;
            return v;
        end
        t = v & ((1 << ow) - 1);
        if (t > hi) t = t - (1 << ow);
        return t;
    endfunction

    function automatic tile_t make_tile(input int even_col, input int odd_col);
        tile_t t;
        for (int e = 0; e < 20; e++) t.c[e] = ((e % 5) % 2 == 0) ? even_col : odd_col;
        return t;
    endfunction

    // Reference from first principles: count matches over all beats, then map to +/-1 or 0/1.
    function automatic tile_t model();
        tile_t t;
        int cnt;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 5; j++) begin
                cnt = 0;
                for (int d = 0; d < 3; d++) begin
                    for (int k = 0; k < 3; k++) begin
                        if (rec_m) cnt += int'(rec_a[d][i*3+k] & rec_b[d][k*5+j]);
                        else       cnt += int'(rec_a[d][i*3+k] == rec_b[d][k*5+j]);
                    end
                end
                t.c[i*5+j] = rec_m ? cnt : 2 * cnt - 9;
            end
        end
        return t;
    endfunction

    task automatic push3(input tile_t t8, input tile_t t4s, input tile_t t4t);
        q8.push_back(t8);
        q4s.push_back(t4s);
        q4t.push_back(t4t);
    endtask

    task automatic push_model();
        tile_t r, s, u;
        r = model();
        for (int e = 0; e < 20; e++) begin
            s.c[e] = cast_v(r.c[e], 4, 1'b1);
            u.c[e] = cast_v(r.c[e], 4, 1'b0);
        end
        push3(r, s, u);
    endtask

    task automatic cmp_tile(input string nm, input logic [159:0] flat, input int ow, input tile_t t);
        int first = -1;
        int got = 0;
        int g;
        logic [159:0] sh;
        for (int e = 0; e < 20; e++) begin
            sh = flat >> (e * ow);
            g = int'(sh[15:0]) & ((1 << ow) - 1);
            if (g >= (1 << (ow - 1))) g = g - (1 << ow);
            if (g != t.c[e] && first < 0) begin
                first = e;
                got = g;
            end
        end
        total++;
        if (first >= 0) begin
            bad++;
            $display("FAIL %s elem %0d: got %0d expected %0d at %0t", nm, first, got, t.c[first], $time);
        end
    endtask

    // Monitor: every output handshake pops and checks the oldest expected tile of that core.
    initial begin
        tile_t t;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (b8.data_out_valid && oready) begin
                    if (q8.size() == 0) chk("unexpected_tile8", 1, 0);
                    else begin t = q8.pop_front(); cmp_tile("tile8", 160'(b8.data_out), 8, t); end
                end
                if (b4s.data_out_valid && oready) begin
                    if (q4s.size() == 0) chk("unexpected_tile4s", 1, 0);
                    else begin t = q4s.pop_front(); cmp_tile("tile4sat", 160'(b4s.data_out), 4, t); end
                end
                if (b4t.data_out_valid && oready) begin
                    if (q4t.size() == 0) chk("unexpected_tile4t", 1, 0);
                    else begin t = q4t.pop_front(); cmp_tile("tile4trunc", 160'(b4t.data_out), 4, t); end
                end
            end
        end
    end

    // One beat: present at posedge+1, wait (bounded) for ready seen at negedge, fire at posedge.
    task automatic beat(input logic [11:0] a, input logic [14:0] b, input logic m);
        int n = 0;
        d1 = a; d2 = b; mode = m; v1 = 1'b1; v2 = 1'b1;
        @(negedge clk);
        while (!b8.data_in1_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("ready_timeout", 0, 1);
            v1 = 1'b0; v2 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [14:0] B_ALT = {5'b10101, 5'b01010, 5'b10101};

    initial begin
        int n;
        logic [159:0] held;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(b8.data_out_valid), 0);
        chk("rst_busy", int'(b8.busy), 0);
        chk("rst_dout_zero", int'(b8.data_out == '0), 1);
        rst = 1'b0;
        idle(1);

        // XNOR all-match with latency/busy checks
        beat(12'hFFF, 15'h7FFF, 1'b0);
        beat(12'hFFF, 15'h7FFF, 1'b0);
        chk("busy_mid_tile", int'(b8.busy), 1);
        chk("no_early_valid", int'(b8.data_out_valid), 0);
        beat(12'hFFF, 15'h7FFF, 1'b0);
        push3(make_tile(9, 9), make_tile(7, 7), make_tile(-7, -7));
        chk("latency_valid", int'(b8.data_out_valid), 1);
        chk("busy_after_last", int'(b8.busy), 0);

        for (int d = 0; d < 3; d++) beat(12'hFFF, 15'h0000, 1'b0);
        push3(make_tile(-9, -9), make_tile(-8, -8), make_tile(7, 7));
        for (int d = 0; d < 3; d++) beat(12'hFFF, 15'h7FFF, 1'b1);
        push3(make_tile(9, 9), make_tile(7, 7), make_tile(-7, -7));
        for (int d = 0; d < 3; d++) beat(12'hFFF, 15'h0000, 1'b1);
        push3(make_tile(0, 0), make_tile(0, 0), make_tile(0, 0));
        for (int d = 0; d < 3; d++) beat(12'hFFF, B_ALT, 1'b1);
        push3(make_tile(6, 3), make_tile(6, 3), make_tile(6, 3));

        // mode follows the first beat of the tile only
        beat(12'hFFF, 15'h0000, 1'b0);
        beat(12'hFFF, 15'h0000, 1'b1);
        beat(12'hFFF, 15'h0000, 1'b1);
        push3(make_tile(-9, -9), make_tile(-8, -8), make_tile(7, 7));
        beat(12'hFFF, 15'h0000, 1'b1);
        beat(12'hFFF, 15'h0000, 1'b0);
        beat(12'hFFF, 15'h0000, 1'b0);
        push3(make_tile(0, 0), make_tile(0, 0), make_tile(0, 0));
        idle(2);

        // backpressure: held tile, two beats accepted, last beat stalls, then drain+reload
        oready = 1'b0;
        for (int d = 0; d < 3; d++) beat(12'hFFF, 15'h7FFF, 1'b0);
        push3(make_tile(9, 9), make_tile(7, 7), make_tile(-7, -7));
        beat(12'hFFF, 15'h0000, 1'b0);
        beat(12'hFFF, 15'h0000, 1'b0);
        d1 = 12'hFFF; d2 = 15'h0000; mode = 1'b0; v1 = 1'b1; v2 = 1'b1;
        #1;
        chk("bp_last_stalled", int'(b8.data_in1_ready), 0);
        chk("bp_in2_stalled", int'(b8.data_in2_ready), 0);
        held = 160'(b8.data_out);
        idle(1);
        chk("bp_hold_valid", int'(b8.data_out_valid), 1);
        chk("bp_hold_data", int'(160'(b8.data_out) == held), 1);
        chk("bp_still_stalled", int'(b8.data_in1_ready), 0);
        oready = 1'b1;
        #1;
        chk("bp_ready_on_drain", int'(b8.data_in1_ready), 1);
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0;
        push3(make_tile(-9, -9), make_tile(-8, -8), make_tile(7, 7));
        chk("bp_reload_valid", int'(b8.data_out_valid), 1);
        chk("bp_reload_elem0", int'($signed(b8.data_out[7:0])), -9);
        idle(3);

        // reset mid-tile discards the partial tile
        beat(12'hFFF, 15'h0000, 1'b0);
        beat(12'hFFF, 15'h0000, 1'b0);
        rst = 1'b1;
        idle(1);
        chk("rst_mid_busy", int'(b8.busy), 0);
        chk("rst_mid_valid", int'(b8.data_out_valid), 0);
        rst = 1'b0;
        idle(1);
        for (int d = 0; d < 3; d++) beat(12'hFFF, 15'h7FFF, 1'b0);
        push3(make_tile(9, 9), make_tile(7, 7), make_tile(-7, -7));
        idle(3);

        // random tiles with random input gaps and output stalls
        fork
            begin
                logic m;
                for (int t = 0; t < 1000; t++) begin
                    for (int d = 0; d < 3; d++) begin
                        rec_a[d] = 12'($urandom);
                        rec_b[d] = 15'($urandom);
                        m = 1'($urandom_range(0, 1));
                        if (d == 0) rec_m = m;
                        if ($urandom_range(0, 3) == 0) idle(1);
                        beat(rec_a[d], rec_b[d], m);
                    end
                    push_model();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    oready = ($urandom_range(0, 2) != 0);
                end
                oready = 1'b1;
            end
        join

        n = 0;
        while ((q8.size() != 0 || q4s.size() != 0 || q4t.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        chk("drain_q8", q8.size(), 0);
        chk("drain_q4s", q4s.size(), 0);
        chk("drain_q4t", q4t.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
